data_offload_wr_ctrl: RTL
=========================

# data_offload_wr_ctrl

Write-side control engine for the data offload storage path. It responds to the transfer-request stimulus (`init_req`, `sync_ext`, `src_valid`) produced by the source or test program. It arms on an init request, waits for the configured synchronisation event, then streams source beats into storage with an incrementing write address. On completion it reports the last written address. It sits between the source AXI-Stream interface and the storage write port, in the source clock domain.

## Interface
- `ADDR_WIDTH`, 10, storage address width; capacity 2^ADDR_WIDTH beats
- `DATA_WIDTH`, 64, source/storage data width
- `clk` in 1: source clock
- `rst` in 1: asynchronous, active-high reset
- `init_req` in 1: level transfer request; rising edge arms, deassertion aborts/terminates
- `sync_config` in 2: 0 = autonomous, 1 = hardware sync (`sync_ext`), 2 = software sync (`sync_sw`), 3 = treated as 0
- `sync_ext` in 1: external sync; rising edge is the event
- `sync_sw` in 1: single-cycle software sync strobe
- `transfer_length` in ADDR_WIDTH: last address of the transfer; length = value + 1 beats
- `src_valid` in 1, `src_data` in DATA_WIDTH, `src_last` in 1: source stream
- `src_ready` out 1: source handshake
- `mem_we` out 1, `mem_waddr` out ADDR_WIDTH, `mem_wdata` out DATA_WIDTH: registered storage write port
- `wr_last_addr` out ADDR_WIDTH: address of final beat of last completed transfer
- `wr_done` out 1: one-cycle completion pulse
- `wr_busy` out 1: high in WAIT_SYNC or WRITE

## Operation
- States: IDLE, WAIT_SYNC, WRITE, DONE
- `init_req` and `sync_ext` delayed one register each; rising edge = current 1 and previous 0
- IDLE: `src_ready`=0. `init_req` rising edge -> WAIT_SYNC, or -> WRITE when `sync_config` is 0 or 3; write address cleared to 0
- WAIT_SYNC: `src_ready`=1. Accepted beats are discarded, no `mem_we`
  - Mode 1: `sync_ext` rising edge -> WRITE. Mode 2: `sync_sw`=1 -> WRITE
  - `init_req`=0 -> IDLE, no `wr_done`
- WRITE: `src_ready`=1. Each `src_valid` beat writes at the current address; address then increments
  - Terminating beat: `src_last`=1, or address == `transfer_length`, or address == 2^ADDR_WIDTH-1
  - Terminating beat is written; FSM -> DONE; `wr_last_addr` latches that address
  - `init_req`=0 in WRITE: a beat accepted in that same cycle is written and treated as terminating. If ≥1 beat was written -> DONE with `wr_last_addr` = last written address; else -> IDLE, no `wr_done`
- DONE: `src_ready`=0, `wr_done`=1 for exactly one cycle, then IDLE
  - Re-arm requires a new `init_req` rising edge; a level held high does not restart
- `transfer_length` and `sync_config` are sampled at arm (IDLE exit) and held for the transfer
- Address arithmetic: unsigned ADDR_WIDTH, never wraps within a transfer (capacity check terminates first)

## Timing
- Reset values: `src_ready`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `wr_last_addr`=0, `wr_done`=0, `wr_busy`=0; state IDLE
- `init_req` rises in cycle n (edge seen in n) -> state changes at edge n+1; `src_ready`=1 from n+1
- `sync_ext` rises in cycle n -> WRITE from n+1; beats in cycle n are discarded
- `sync_sw` in cycle n -> WRITE from n+1
- Write latency: beat accepted in cycle n -> `mem_we`/`mem_waddr`/`mem_wdata` valid in n+1, one cycle wide
- Terminating beat accepted in cycle n -> DONE in n+1 (`wr_done`=1, `src_ready`=0, `mem_we`=1 for that beat) -> IDLE in n+2
- `wr_last_addr` updates in the same cycle `wr_done` asserts
- `src_ready` is a registered function of state only; it never depends combinationally on `src_valid`
- Async `rst` mid-transfer: immediate return to reset values; no `wr_done`

## Test plan
- Autonomous: `sync_config`=0, `transfer_length`=7, `init_req` rises, 8 continuous beats (data 0..7) -> writes addr 0..7 with data 0..7; `wr_done` 1 cycle after beat 7; `wr_last_addr`=7; `src_ready`=0 in DONE
- Hardware sync: `sync_config`=1, 5 beats before `sync_ext` rise are discarded; `sync_ext` rises, then `transfer_length`=3 -> exactly 4 writes at addr 0..3 with post-sync data
- `src_last` early: `transfer_length`=15, `src_last` on 6th beat -> writes addr 0..5; `wr_last_addr`=5
- Capacity: `ADDR_WIDTH`=4, `transfer_length`=15, no `src_last` -> 16 writes, terminates at addr 15, no wrap, `wr_done` once
- Aborts: `init_req` falls in WAIT_SYNC -> IDLE, no writes, no `wr_done`. `init_req` falls after 3 beats in WRITE -> `wr_done` with `wr_last_addr`=2. `init_req` held high after DONE -> no re-arm
- Reset: assert `rst` mid-WRITE -> all outputs 0 immediately; after release, a fresh `init_req` rise starts again at addr 0

Source files
------------

// File: rtl/data_offload_wr_ctrl.sv
// Write-side control engine for the data offload storage path: arms on an init
// request, waits for the selected sync event, then streams source beats into storage.
module data_offload_wr_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  init_req_i,
  input  logic [1:0]            sync_config_i,
  input  logic                  sync_ext_i,
  input  logic                  sync_sw_i,
  input  logic [ADDR_WIDTH-1:0] transfer_length_i,
  input  logic                  src_valid_i,
  input  logic [DATA_WIDTH-1:0] src_data_i,
  input  logic                  src_last_i,
  output logic                  src_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [ADDR_WIDTH-1:0] wr_last_addr_o,
  output logic                  wr_done_o,
  output logic                  wr_busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_WRITE     = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};

  state_t                  state_q, state_d;
  logic                    init_req_q;
  logic                    sync_ext_q;
  logic [1:0]              cfg_q, cfg_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    src_ready_q, src_ready_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_waddr_q, mem_waddr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-1:0]   wr_last_addr_q, wr_last_addr_d;
  logic                    wr_done_q, wr_done_d;
  logic                    wr_busy_q, wr_busy_d;

  logic                    init_rise_s;
  logic                    ext_rise_s;
  logic                    beat_s;

  assign init_rise_s = init_req_i & ~init_req_q;
  assign ext_rise_s  = sync_ext_i & ~sync_ext_q;
  // src_ready is registered from state, so the handshake never loops through src_valid
  assign beat_s      = src_valid_i & src_ready_q;

  // Next-state, address and write-port computation
  always_comb begin
    state_d        = state_q;
    cfg_d          = cfg_q;
    len_d          = len_q;
    addr_d         = addr_q;
    mem_we_d       = 1'b0;
    mem_waddr_d    = mem_waddr_q;
    mem_wdata_d    = mem_wdata_q;
    wr_last_addr_d = wr_last_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (init_rise_s) begin
          addr_d = ADDR_ZERO;
          cfg_d  = sync_config_i;
          len_d  = transfer_length_i;
          if ((sync_config_i == 2'd1) || (sync_config_i == 2'd2)) begin
            state_d = ST_WAIT_SYNC;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_SYNC: begin
        if (!init_req_i) begin
          state_d = ST_IDLE;
        end else if ((cfg_q == 2'd1) && ext_rise_s) begin
          state_d = ST_WRITE;
        end else if ((cfg_q == 2'd2) && sync_sw_i) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_WAIT_SYNC;
        end
      end
      ST_WRITE: begin
        if (beat_s) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = addr_q;
          mem_wdata_d = src_data_i;
          // Capacity check ends the transfer before the address could wrap
          if (!init_req_i || src_last_i || (addr_q == len_q) || (addr_q == ADDR_MAX)) begin
            state_d        = ST_DONE;
            wr_last_addr_d = addr_q;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end else if (!init_req_i) begin
          if (addr_q != ADDR_ZERO) begin
            state_d        = ST_DONE;
            wr_last_addr_d = addr_q - ADDR_ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    src_ready_d = (state_d == ST_WAIT_SYNC) || (state_d == ST_WRITE);
    wr_busy_d   = src_ready_d;
    wr_done_d   = (state_d == ST_DONE);
  end

  // State, edge-detect history and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      init_req_q     <= 1'b0;
      sync_ext_q     <= 1'b0;
      cfg_q          <= 2'd0;
      len_q          <= ADDR_ZERO;
      addr_q         <= ADDR_ZERO;
      src_ready_q    <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_waddr_q    <= ADDR_ZERO;
      mem_wdata_q    <= {DATA_WIDTH{1'b0}};
      wr_last_addr_q <= ADDR_ZERO;
      wr_done_q      <= 1'b0;
      wr_busy_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_req_q     <= init_req_i;
      sync_ext_q     <= sync_ext_i;
      cfg_q          <= cfg_d;
      len_q          <= len_d;
      addr_q         <= addr_d;
      src_ready_q    <= src_ready_d;
      mem_we_q       <= mem_we_d;
      mem_waddr_q    <= mem_waddr_d;
      mem_wdata_q    <= mem_wdata_d;
      wr_last_addr_q <= wr_last_addr_d;
      wr_done_q      <= wr_done_d;
      wr_busy_q      <= wr_busy_d;
    end
  end

  assign src_ready_o    = src_ready_q;
  assign mem_we_o       = mem_we_q;
  assign mem_waddr_o    = mem_waddr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign wr_last_addr_o = wr_last_addr_q;
  assign wr_done_o      = wr_done_q;
  assign wr_busy_o      = wr_busy_q;

endmodule
